// File: rtl/mesh_input_dispatch.sv
// Mesh front-end loader: captures per-channel config and data words on one load,
// then each channel strobes its config and streams its words under valid/ready.

module mesh_input_dispatch_ch #(
  parameter int DATA_W = 32,
  parameter int CONF_W = 64,
  parameter int WORDS  = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        accept,
  input  logic [CONF_W-1:0]           conf_in,
  input  logic [WORDS-1:0][DATA_W-1:0] data_in,
  input  logic                        data_ready,
  output logic                        idle,
  output logic [CONF_W-1:0]           conf_out,
  output logic                        conf_strobe,
  output logic [DATA_W-1:0]           data_out,
  output logic                        data_valid,
  output logic                        done
);
  localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, CONF, DATA, DONE} state_t;

  typedef struct packed {
    logic [CONF_W-1:0]            conf;
    logic [WORDS-1:0][DATA_W-1:0] words;
  } cap_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  idx, idx_nx;
  cap_t              cap_q;
  logic [DATA_W-1:0] cur_word;

  generate
    if (WORDS == 1) begin : g_one
      assign cur_word = cap_q.words[0];
    end else begin : g_many
      assign cur_word = cap_q.words[idx];
    end
  endgenerate

  // Buffers are cleared on reset so an aborted load leaves nothing behind.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
      cap_q <= '0;
    end else begin
      state <= state_nx;
      idx   <= idx_nx;
      if (accept) begin
        cap_q.conf  <= conf_in;
        cap_q.words <= data_in;
      end
    end
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    idle        = 1'b0;
    conf_strobe = 1'b0;
    data_valid  = 1'b0;
    data_out    = '0;
    done        = 1'b0;
    case (state)
      IDLE: begin
        idle = 1'b1;
        if (accept) begin
          state_nx = CONF;
          idx_nx   = '0;
        end
      end
      CONF: begin
        conf_strobe = 1'b1;
        state_nx    = DATA;
      end
      DATA: begin
        data_valid = 1'b1;
        data_out   = cur_word;
        if (data_ready) begin
          if (idx == LAST) state_nx = DONE;
          else             idx_nx   = idx + IDX_W'(1);
        end
      end
      DONE: begin
        done     = 1'b1;
        state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  assign conf_out = cap_q.conf;
endmodule

module mesh_input_dispatch #(
  parameter int NUM_CH       = 4,
  parameter int DATA_W       = 32,
  parameter int CONF_W       = 64,
  parameter int WORDS_PER_CH = 2,
  parameter int DROP_CNT_W   = 8
) (
  input  logic                                          clk,
  input  logic                                          reset,
  input  logic                                          load,
  input  logic [NUM_CH-1:0][CONF_W-1:0]                 conf_in,
  input  logic [NUM_CH-1:0][WORDS_PER_CH-1:0][DATA_W-1:0] data_in,
  output logic                                          load_ready,
  output logic [NUM_CH-1:0][CONF_W-1:0]                 conf_out,
  output logic [NUM_CH-1:0]                             conf_strobe,
  output logic [NUM_CH-1:0][DATA_W-1:0]                 data_out,
  output logic [NUM_CH-1:0]                             data_valid,
  input  logic [NUM_CH-1:0]                             data_ready,
  output logic [NUM_CH-1:0]                             done,
  output logic                                          all_done,
  output logic [DROP_CNT_W-1:0]                         dropped_loads
);
  logic [NUM_CH-1:0] idle;
  logic [NUM_CH-1:0] pending;
  logic              accept;

  assign load_ready = &idle;
  assign accept     = load & load_ready;

  genvar c;
  generate
    for (c = 0; c < NUM_CH; c++) begin : g_ch
      mesh_input_dispatch_ch #(
        .DATA_W (DATA_W),
        .CONF_W (CONF_W),
        .WORDS  (WORDS_PER_CH)
      ) u_ch (
        .clk         (clk),
        .reset       (reset),
        .accept      (accept),
        .conf_in     (conf_in[c]),
        .data_in     (data_in[c]),
        .data_ready  (data_ready[c]),
        .idle        (idle[c]),
        .conf_out    (conf_out[c]),
        .conf_strobe (conf_strobe[c]),
        .data_out    (data_out[c]),
        .data_valid  (data_valid[c]),
        .done        (done[c])
      );
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending       <= '0;
      dropped_loads <= '0;
    end else begin
      if (accept) pending <= '1;
      else        pending <= pending & ~done;
      if (load && !load_ready && (dropped_loads != '1))
        dropped_loads <= dropped_loads + DROP_CNT_W'(1);
    end
  end

  // Single pulse even when several final dones coincide.
  assign all_done = (|(pending & done)) && ((pending & ~done) == '0);
endmodule
